door_controller: RTL and testbench
==================================

// Module: door_controller
// PURPOSE
// - Parametrised multi-door gate controller for the parking system; one
//   independent channel per entry/exit door, all on the shared 2 Hz tick.
// - Each channel opens on request, drives its door LED for a programmable
//   hold time, and closes automatically.
// - Adds obstruction hold, re-trigger extension, forced close, a solid/blink
//   LED mode and a close-done pulse, so the lot FSM can count vehicles.
// PARAMETERS
// - NUM_DOORS   2    number of independent door channels (>=1)
// - OPEN_TICKS  20   hold time in clk_2Hz cycles (>=1); 20 = 10 s
// - BLINK_MODE  1    1: LED toggles each tick while open; 0: LED solid 1
// - RETRIGGER   1    1: open_req while open restarts hold; 0: ignored
// PORTS
// - clk_2Hz      in   1          2 Hz system tick; all logic on posedge
// - reset        in   1          async, active-low; clears every channel
// - open_req     in   NUM_DOORS  per-door open request, level-sampled
// - obstruct     in   NUM_DOORS  per-door sensor; holds door open while 1
// - force_close  in   NUM_DOORS  per-door immediate close (supervisor)
// - door_led     out  NUM_DOORS  door indicator / actuator
// - door_busy    out  NUM_DOORS  1 while channel is in OPEN
// - close_done   out  NUM_DOORS  1-cycle pulse on each OPEN->IDLE exit
// - any_busy     out  1          OR of door_busy
// BEHAVIOUR
// - Reset (reset=0, async): state=IDLE, cnt=0, door_led=0, close_done=0,
//   door_busy=0, any_busy=0. Reset mid-OPEN aborts with no close_done.
// - Per channel: 2-state FSM IDLE/OPEN plus cnt, width $clog2(OPEN_TICKS+1).
// - door_busy = (state==OPEN), combinational from state; any_busy = |door_busy.
// - IDLE: open_req=1 and force_close=0 -> OPEN, cnt=0,
//   door_led = BLINK_MODE ? 0 : 1. Otherwise stay; door_led=0.
// - OPEN: per-edge priority, highest first:
//   1 force_close=1 -> IDLE, cnt=0, door_led=0, close_done=1.
//   2 obstruct=1 -> cnt=0, stay OPEN, LED rule applies.
//   3 open_req=1 and RETRIGGER=1 -> cnt=0, stay OPEN, LED rule applies.
//   4 cnt<OPEN_TICKS -> cnt=cnt+1; LED rule applies.
//   5 cnt==OPEN_TICKS -> IDLE, cnt=0, door_led=0, close_done=1.
// - LED rule in OPEN: BLINK_MODE=1 toggles door_led; BLINK_MODE=0 holds 1.
// - Nominal latency: request edge k -> LED activity on edges k+1..k+OPEN_TICKS
//   -> close on edge k+OPEN_TICKS+1.
// - Terminal edge (cnt==OPEN_TICKS) with open_req=1:
//   RETRIGGER=1 -> stays OPEN, cnt=0, no close_done; RETRIGGER=0 -> closes.
// - close_done is registered, high for exactly the cycle after the closing
//   edge, and cleared on every other edge.
// - Channels are fully independent; simultaneous events on different doors
//   do not interact.
// - cnt never exceeds OPEN_TICKS; no wrap-around is possible.
// STRUCTURE
// - door_pkg: state encodings (ST_IDLE, ST_OPEN) and a clog2 width helper,
//   shared with the lot FSM.
// - Sub-module door_channel: one FSM, counter and LED register, built from
//   a generate loop NUM_DOORS times. The top level holds any_busy and the
//   generate loop only.
// TESTING
// - Basic (OPEN_TICKS=20, BLINK): open_req[0] 1-cycle pulse at edge 0 ->
//   door_led[0] toggles on edges 1..20, door_busy[0]=1 for cycles after edges
//   0..20, close_done[0] pulse after edge 21, door_led[0]=0 afterwards.
// - Obstruction: obstruct[0]=1 for edges 10..15 -> cnt reloads to 0, close
//   moves to edge 36, LED keeps toggling throughout.
// - Retrigger: RETRIGGER=1, open_req at edges 0 and 20 -> close at edge 41,
//   single close_done; RETRIGGER=0, same stimulus -> close at edge 21.
// - Force close: force_close[1] at edge 5 of OPEN -> door_led[1]=0,
//   close_done[1]=1 next cycle; force_close with open_req in IDLE -> no open.
// - Independence and solid mode: BLINK_MODE=0, doors 0 and 1 opened on edges
//   0 and 3 -> LEDs solid 1, close_done on edges 21 and 24, any_busy over
//   edges 0..24.
// - Reset mid-operation: reset=0 asynchronously during OPEN (edge 8) ->
//   all outputs 0 at once, no close_done, next open_req restarts cleanly.

Source files
------------

// File: rtl/door_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : door_pkg
//  Description : Shared door-channel state encodings and counter width helper
//                used by the door controller and the lot FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
package door_pkg;

    // Per-channel door state; explicit one-bit encoding
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OPEN = 1'b1
    } door_state_e;

    // Bits needed to hold a hold counter that runs 0..ticks inclusive
    function automatic int cnt_width(input int unsigned ticks);
        int w;
        w = $clog2(ticks + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : door_pkg
`default_nettype wire

// File: rtl/door_channel.sv
`default_nettype none
// ============================================================================
//  Module      : door_channel
//  Description : One door channel: IDLE/OPEN FSM, hold counter, LED register
//                and registered close-done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module door_channel
    import door_pkg::*;
#(
    parameter int unsigned OPEN_TICKS = 20,
    parameter bit          BLINK_MODE = 1'b1,
    parameter bit          RETRIGGER  = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic open_req_i,
    input  logic obstruct_i,
    input  logic force_close_i,
    output logic door_led_o,
    output logic door_busy_o,
    output logic close_done_o
);

    localparam int               CNT_W = cnt_width(OPEN_TICKS);
    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(OPEN_TICKS);

    door_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             led_q, led_d;
    logic             done_q, done_d;
    logic             led_open;

    // LED value while the door stays open: toggle in blink mode, else solid on
    assign led_open = BLINK_MODE ? ~led_q : 1'b1;

    // State, counter, LED and done registers; reset aborts without a pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            led_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; OPEN events are resolved in fixed priority order
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        led_d   = led_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (open_req_i && !force_close_i) begin
                    state_d = ST_OPEN;
                    led_d   = ~BLINK_MODE;
                end else begin
                    led_d   = 1'b0;
                end
            end
            ST_OPEN: begin
                if (force_close_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    led_d   = 1'b0;
                    done_d  = 1'b1;
                end else if (obstruct_i) begin
                    cnt_d   = '0;
                    led_d   = led_open;
                end else if (open_req_i && RETRIGGER) begin
                    cnt_d   = '0;
                    led_d   = led_open;
                end else if (cnt_q < C_MAX) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    led_d   = led_open;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    led_d   = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                led_d   = 1'b0;
            end
        endcase
    end

    assign door_led_o   = led_q;
    assign door_busy_o  = (state_q == ST_OPEN);
    assign close_done_o = done_q;

endmodule : door_channel
`default_nettype wire

// File: rtl/door_controller.sv
`default_nettype none
// ============================================================================
//  Module      : door_controller
//  Description : Multi-door gate controller; NUM_DOORS independent channels
//                on the shared 2 Hz tick plus a combined busy flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module door_controller
    import door_pkg::*;
#(
    parameter int unsigned NUM_DOORS  = 2,
    parameter int unsigned OPEN_TICKS = 20,
    parameter bit          BLINK_MODE = 1'b1,
    parameter bit          RETRIGGER  = 1'b1
) (
    input  logic                 clk_2Hz,
    input  logic                 reset,
    input  logic [NUM_DOORS-1:0] open_req,
    input  logic [NUM_DOORS-1:0] obstruct,
    input  logic [NUM_DOORS-1:0] force_close,
    output logic [NUM_DOORS-1:0] door_led,
    output logic [NUM_DOORS-1:0] door_busy,
    output logic [NUM_DOORS-1:0] close_done,
    output logic                 any_busy
);

    // One fully independent channel per door
    for (genvar gi = 0; gi < NUM_DOORS; gi++) begin : g_door
        door_channel #(
            .OPEN_TICKS (OPEN_TICKS),
            .BLINK_MODE (BLINK_MODE),
            .RETRIGGER  (RETRIGGER)
        ) u_channel (
            .clk_i         (clk_2Hz),
            .rst_ni        (reset),
            .open_req_i    (open_req[gi]),
            .obstruct_i    (obstruct[gi]),
            .force_close_i (force_close[gi]),
            .door_led_o    (door_led[gi]),
            .door_busy_o   (door_busy[gi]),
            .close_done_o  (close_done[gi])
        );
    end

    assign any_busy = |door_busy;

endmodule : door_controller
`default_nettype wire

// File: tb/tb_door_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_door_controller
//  Description : Table-driven bench for door_controller; three instances
//                cover blink+retrigger, blink without retrigger, solid LED.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_door_controller;

    typedef struct packed {
        logic [1:0] open_req;
        logic [1:0] obstruct;
        logic [1:0] force_close;
        logic [1:0] exp_led;
        logic [1:0] exp_busy;
        logic [1:0] exp_done;
        logic       exp_any;
    } vec_t;

    logic       clk_2Hz = 1'b0;
    logic       reset   = 1'b0;
    logic [1:0] open_req    = '0;
    logic [1:0] obstruct    = '0;
    logic [1:0] force_close = '0;

    logic [1:0] led  [3];
    logic [1:0] busy [3];
    logic [1:0] done [3];
    logic       anyb [3];

    vec_t vecs [64];
    int   nvec;
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk_2Hz = ~clk_2Hz;

    // Instance 0: blink, retrigger on
    door_controller #(.NUM_DOORS(2), .OPEN_TICKS(20), .BLINK_MODE(1'b1), .RETRIGGER(1'b1)) u_dut_a (
        .clk_2Hz(clk_2Hz), .reset(reset), .open_req(open_req), .obstruct(obstruct),
        .force_close(force_close), .door_led(led[0]), .door_busy(busy[0]),
        .close_done(done[0]), .any_busy(anyb[0]));

    // Instance 1: blink, retrigger off
    door_controller #(.NUM_DOORS(2), .OPEN_TICKS(20), .BLINK_MODE(1'b1), .RETRIGGER(1'b0)) u_dut_b (
        .clk_2Hz(clk_2Hz), .reset(reset), .open_req(open_req), .obstruct(obstruct),
        .force_close(force_close), .door_led(led[1]), .door_busy(busy[1]),
        .close_done(done[1]), .any_busy(anyb[1]));

    // Instance 2: solid LED, retrigger on
    door_controller #(.NUM_DOORS(2), .OPEN_TICKS(20), .BLINK_MODE(1'b0), .RETRIGGER(1'b1)) u_dut_c (
        .clk_2Hz(clk_2Hz), .reset(reset), .open_req(open_req), .obstruct(obstruct),
        .force_close(force_close), .door_led(led[2]), .door_busy(busy[2]),
        .close_done(done[2]), .any_busy(anyb[2]));

    function automatic logic in_rng(input int e, input int lo, input int hi);
        return (e >= lo) && (e <= hi);
    endfunction

    // Blinking LED value after edge e for a door that opened on edge k and stays open through hi
    function automatic logic blink(input int e, input int k, input int hi);
        return in_rng(e, k + 1, hi) && (((e - k) % 2) == 1);
    endfunction

    task automatic clear_vecs(input int n);
        nvec = n;
        for (int i = 0; i < 64; i++) vecs[i] = '0;
    endtask

    task automatic finish_any();
        for (int i = 0; i < nvec; i++) vecs[i].exp_any = |vecs[i].exp_busy;
    endtask

    task automatic check_out(input int sel, input string name, input int edge_no,
                             input logic [6:0] want);
        logic [6:0] got;
        got = {led[sel], busy[sel], done[sel], anyb[sel]};
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s edge %0d: got led=%b busy=%b done=%b any=%b, want led=%b busy=%b done=%b any=%b",
                     name, edge_no, got[6:5], got[4:3], got[2:1], got[0],
                     want[6:5], want[4:3], want[2:1], want[0]);
        end
    endtask

    // Apply each vector before its edge, compare just after that edge
    task automatic run_table(input int sel, input string name);
        for (int i = 0; i < nvec; i++) begin
            @(negedge clk_2Hz);
            open_req    = vecs[i].open_req;
            obstruct    = vecs[i].obstruct;
            force_close = vecs[i].force_close;
            @(posedge clk_2Hz);
            #2;
            check_out(sel, name, i, {vecs[i].exp_led, vecs[i].exp_busy,
                                     vecs[i].exp_done, vecs[i].exp_any});
        end
        @(negedge clk_2Hz);
        open_req    = '0;
        obstruct    = '0;
        force_close = '0;
    endtask

    task automatic do_reset();
        @(negedge clk_2Hz);
        reset = 1'b0;
        repeat (2) @(posedge clk_2Hz);
        #2;
        for (int s = 0; s < 3; s++) check_out(s, "reset_state", 0, 7'b0);
        @(negedge clk_2Hz);
        reset = 1'b1;
    endtask

    task automatic build_basic();
        clear_vecs(25);
        vecs[0].open_req = 2'b01;
        for (int e = 0; e < nvec; e++) begin
            vecs[e].exp_busy[0] = in_rng(e, 0, 20);
            vecs[e].exp_led[0]  = blink(e, 0, 20);
            vecs[e].exp_done[0] = (e == 21);
        end
        finish_any();
    endtask

    initial begin
        // Reset state of all instances
        do_reset();

        // Basic open / hold / auto-close
        build_basic();
        run_table(0, "basic");

        // Obstruction reloads the counter on edges 10..15
        do_reset();
        clear_vecs(40);
        vecs[0].open_req = 2'b01;
        for (int e = 10; e <= 15; e++) vecs[e].obstruct = 2'b01;
        for (int e = 0; e < nvec; e++) begin
            vecs[e].exp_busy[0] = in_rng(e, 0, 35);
            vecs[e].exp_led[0]  = blink(e, 0, 35);
            vecs[e].exp_done[0] = (e == 36);
        end
        finish_any();
        run_table(0, "obstruct");

        // Retrigger on terminal-minus-one edge, enabled
        do_reset();
        clear_vecs(44);
        vecs[0].open_req  = 2'b01;
        vecs[20].open_req = 2'b01;
        for (int e = 0; e < nvec; e++) begin
            vecs[e].exp_busy[0] = in_rng(e, 0, 40);
            vecs[e].exp_led[0]  = blink(e, 0, 40);
            vecs[e].exp_done[0] = (e == 41);
        end
        finish_any();
        run_table(0, "retrig_on");

        // Same stimulus, retrigger disabled
        do_reset();
        clear_vecs(25);
        vecs[0].open_req  = 2'b01;
        vecs[20].open_req = 2'b01;
        for (int e = 0; e < nvec; e++) begin
            vecs[e].exp_busy[0] = in_rng(e, 0, 20);
            vecs[e].exp_led[0]  = blink(e, 0, 20);
            vecs[e].exp_done[0] = (e == 21);
        end
        finish_any();
        run_table(1, "retrig_off");

        // Request exactly on the terminal edge, retrigger enabled: stays open
        do_reset();
        clear_vecs(44);
        vecs[0].open_req  = 2'b01;
        vecs[21].open_req = 2'b01;
        for (int e = 0; e < nvec; e++) begin
            vecs[e].exp_busy[0] = in_rng(e, 0, 41);
            vecs[e].exp_led[0]  = blink(e, 0, 41);
            vecs[e].exp_done[0] = (e == 42);
        end
        finish_any();
        run_table(0, "terminal_retrig");

        // Force close door 1 on edge 5, then force+request while idle
        do_reset();
        clear_vecs(12);
        vecs[0].open_req    = 2'b10;
        vecs[5].force_close = 2'b10;
        vecs[8].open_req    = 2'b10;
        vecs[8].force_close = 2'b10;
        for (int e = 0; e < nvec; e++) begin
            vecs[e].exp_busy[1] = in_rng(e, 0, 4);
            vecs[e].exp_led[1]  = blink(e, 0, 4);
            vecs[e].exp_done[1] = (e == 5);
        end
        finish_any();
        run_table(0, "force_close");

        // Solid LED, two doors opened on edges 0 and 3
        do_reset();
        clear_vecs(27);
        vecs[0].open_req = 2'b01;
        vecs[3].open_req = 2'b10;
        for (int e = 0; e < nvec; e++) begin
            vecs[e].exp_busy[0] = in_rng(e, 0, 20);
            vecs[e].exp_led[0]  = in_rng(e, 0, 20);
            vecs[e].exp_done[0] = (e == 21);
            vecs[e].exp_busy[1] = in_rng(e, 3, 23);
            vecs[e].exp_led[1]  = in_rng(e, 3, 23);
            vecs[e].exp_done[1] = (e == 24);
        end
        finish_any();
        run_table(2, "solid_indep");

        // Asynchronous reset in the middle of OPEN
        do_reset();
        clear_vecs(8);
        vecs[0].open_req = 2'b01;
        for (int e = 0; e < nvec; e++) begin
            vecs[e].exp_busy[0] = 1'b1;
            vecs[e].exp_led[0]  = blink(e, 0, 20);
        end
        finish_any();
        run_table(0, "pre_reset");
        #1;
        reset = 1'b0;
        #1;
        check_out(0, "async_reset", 8, 7'b0);
        open_req = 2'b11;
        for (int e = 9; e < 12; e++) begin
            @(posedge clk_2Hz);
            #2;
            check_out(0, "held_reset", e, 7'b0);
        end
        @(negedge clk_2Hz);
        open_req = '0;
        reset    = 1'b1;
        @(posedge clk_2Hz);
        #2;
        check_out(0, "after_release", 0, 7'b0);
        build_basic();
        run_table(0, "restart");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_door_controller
`default_nettype wire
